// File: rtl/alu_mc_if.sv
// alu_mc_if -- request/result bundle for the multi-cycle ALU.
//   start, a, b, func : request side (driven by the master)
//   busy, done, y, flags : status/result side (driven by the ALU)
// Parameter N: operand/result width, must match the attached alu_mc.
interface alu_mc_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   func;
    logic         busy;
    logic         done;
    logic [N-1:0] y;
    logic [3:0]   flags;

    modport master (
        output start, a, b, func,
        input  busy, done, y, flags
    );

    modport slave (
        input  start, a, b, func,
        output busy, done, y, flags
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc -- small ALU with single-cycle add/sub/logic/shift operations and an
// optional iterative (one shift-add step per clock) unsigned multiplier.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_mc_if.slave
//            start (request, sampled only when idle), a, b, func (operation),
//            busy (multiply iterating), done (one-cycle result pulse),
//            y (registered result), flags (registered {N,Z,C,V})
//
// func: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 lsl, 110 lsr, 111 mul
//
// Build option: define ALU_MC_MUL_EN to include the multiplier and its MUL
// state. Without it, func=111 completes in one cycle with y=0, flags=4'b0100.
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete on the accept edge
// MUL   | shift-add multiply iterating, one step per edge, busy=1
module alu_mc #(
    parameter int N = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int L = $clog2(N);

    logic [N-1:0] y_q;
    logic [3:0]   flags_q;
    logic         done_q;
    logic         busy_w;

    // Single-cycle ALU result. func=111 falls to the default (y=0) and is only
    // used that way when the multiplier is not built.
    logic [N-1:0] alu_y;
    logic         alu_c;
    logic         alu_v;
    logic [N:0]   wide;
    logic [L-1:0] amt;

    always_comb begin
        alu_y = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        wide  = '0;
        amt   = bus.b[L-1:0];
        case (bus.func)
            3'b000: begin
                wide  = {1'b0, bus.a} + {1'b0, bus.b};
                alu_y = wide[N-1:0];
                alu_c = wide[N];
                alu_v = (bus.a[N-1] == bus.b[N-1]) && (alu_y[N-1] != bus.a[N-1]);
            end
            3'b001: begin
                wide  = {1'b0, bus.a} - {1'b0, bus.b};
                alu_y = wide[N-1:0];
                alu_c = ~wide[N];   // no borrow means a >= b
                alu_v = (bus.a[N-1] != bus.b[N-1]) && (alu_y[N-1] != bus.a[N-1]);
            end
            3'b010: alu_y = bus.a & bus.b;
            3'b011: alu_y = bus.a | bus.b;
            3'b100: alu_y = bus.a ^ bus.b;
            3'b101: begin
                // extra MSB catches the last bit shifted out; stays 0 for amt=0
                wide  = {1'b0, bus.a} << amt;
                alu_y = wide[N-1:0];
                alu_c = wide[N];
            end
            3'b110: begin
                // extra LSB catches the last bit shifted out; stays 0 for amt=0
                wide  = {bus.a, 1'b0} >> amt;
                alu_y = wide[N:1];
                alu_c = wide[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [L-1:0] cnt;
    logic [N-1:0] mcand;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic [N:0]   sum;
    logic [N-1:0] step_hi;
    logic [N-1:0] step_lo;
    logic         is_mul;

    assign is_mul = (bus.func == 3'b111);

    // Right-shifting shift-add: {hi,lo} starts as {0,b}; each step adds mcand
    // into hi when lo[0] is set, then shifts the pair right. After N steps
    // {hi,lo} holds the full 2N-bit product.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        step_hi = sum[N:1];
        step_lo = {sum[0], lo[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start && is_mul) state_nxt = S_MUL;
            S_MUL:   if (cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy_w = (state == S_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            flags_q <= 4'b0000;
            done_q  <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.start) begin
                    if (is_mul) begin
                        mcand <= bus.a;
                        hi    <= '0;
                        lo    <= bus.b;
                        cnt   <= L'(N - 1);
                    end else begin
                        y_q     <= alu_y;
                        flags_q <= {alu_y[N-1], (alu_y == '0), alu_c, alu_v};
                        done_q  <= 1'b1;
                    end
                end
            end else begin
                hi  <= step_hi;
                lo  <= step_lo;
                cnt <= cnt - L'(1);
                if (cnt == '0) begin
                    y_q     <= step_lo;
                    flags_q <= {step_lo[N-1], (step_lo == '0), 1'b0, (step_hi != '0)};
                    done_q  <= 1'b1;
                end
            end
        end
    end
`else
    assign busy_w = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            flags_q <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.start) begin
                y_q     <= alu_y;
                flags_q <= {alu_y[N-1], (alu_y == '0), alu_c, alu_v};
                done_q  <= 1'b1;
            end
        end
    end
`endif

    assign bus.busy  = busy_w;
    assign bus.done  = done_q;
    assign bus.y     = y_q;
    assign bus.flags = flags_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc -- bench for alu_mc (N=32): directed literal cases followed by
// randomized requests, all checked every cycle against an arithmetic model.
// Honours ALU_MC_MUL_EN the same way the design does.
module tb_alu_mc;
    localparam int N = 32;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;

    alu_mc_if #(.N(N)) bus ();

    alu_mc #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    // Reference: result and flags from plain wide arithmetic. Returns {y, flags}.
    function automatic logic [35:0] ref_op(input logic [2:0] f, input logic [31:0] x,
                                           input logic [31:0] z);
        longint      ux, uz, sx, sz, r;
        logic [63:0] p;
        logic [31:0] ry;
        logic        c, v;
        int          amt;
        ux  = longint'({32'b0, x});
        uz  = longint'({32'b0, z});
        sx  = longint'($signed(x));
        sz  = longint'($signed(z));
        c   = 1'b0;
        v   = 1'b0;
        ry  = '0;
        amt = int'(z[4:0]);
        case (f)
            3'd0: begin
                r  = ux + uz;
                ry = r[31:0];
                c  = (r >= 64'h1_0000_0000);
                r  = sx + sz;
                v  = (r != longint'($signed(r[31:0])));
            end
            3'd1: begin
                r  = ux - uz;
                ry = r[31:0];
                c  = (ux >= uz);
                r  = sx - sz;
                v  = (r != longint'($signed(r[31:0])));
            end
            3'd2: ry = x & z;
            3'd3: ry = x | z;
            3'd4: ry = x ^ z;
            3'd5: begin
                ry = x << amt;
                c  = (amt == 0) ? 1'b0 : x[32 - amt];
            end
            3'd6: begin
                ry = x >> amt;
                c  = (amt == 0) ? 1'b0 : x[amt - 1];
            end
            default: begin
                if (MUL_EN) begin
                    p  = {32'b0, x} * {32'b0, z};
                    ry = p[31:0];
                    v  = (p[63:32] != 32'b0);
                end
            end
        endcase
        return {ry, ry[31], (ry == 32'b0), c, v};
    endfunction

    // Cycle model: a request taken while idle completes on the same edge, or
    // N edges later for a multiply; requests during a multiply are dropped.
    logic [35:0] ref_now;
    logic [35:0] m_pend = '0;
    int          m_left = 0;
    logic [31:0] m_y = '0;
    logic [3:0]  m_f = '0;
    logic        m_done = 1'b0;

    assign ref_now = ref_op(bus.func, bus.a, bus.b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_y    <= '0;
            m_f    <= '0;
            m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_y    <= m_pend[35:4];
                m_f    <= m_pend[3:0];
                m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else if (bus.start) begin
            if (bus.func == 3'd7 && MUL_EN) begin
                m_left <= N;
                m_pend <= ref_now;
                m_done <= 1'b0;
            end else begin
                m_y    <= ref_now[35:4];
                m_f    <= ref_now[3:0];
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("y",     64'(bus.y),     64'(m_y));
            chk("flags", 64'(bus.flags), 64'(m_f));
            chk("busy",  64'(bus.busy),  64'(m_left != 0));
            chk("done",  64'(bus.done),  64'(m_done));
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] z);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.func  = f;
        bus.a     = x;
        bus.b     = z;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] z, input logic [31:0] ey, input logic [3:0] ef);
        issue(f, x, z);
        wait_done(nm);
        chk({nm, "_y"},     64'(bus.y),     64'(ey));
        chk({nm, "_flags"}, 64'(bus.flags), 64'(ef));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 7));
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 1'b0;
        bus.func  = 3'd0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_y",     64'(bus.y),     64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op("add_ovf",  3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001);
        run_op("sub_eq",   3'd1, 32'd5,         32'd5,         32'h0000_0000, 4'b0110);
        run_op("sub_neg",  3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000);
        run_op("lsr_1",    3'd6, 32'h8000_0001, 32'd1,         32'h4000_0000, 4'b0010);
        run_op("lsl_0",    3'd5, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 4'b0000);

`ifdef ALU_MC_MUL_EN
        begin
            int busy_cnt;
            bit seen;
            busy_cnt = 0;
            seen     = 1'b0;
            issue(3'd7, 32'h0001_0000, 32'h0001_0000);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                if (bus.busy === 1'b1) busy_cnt++;
                bus.start = (i % 3 == 0);
                bus.func  = 3'($urandom_range(0, 7));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            bus.start = 1'b0;
            chk("mul_done_seen",  64'(seen),      64'd1);
            chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
            chk("mul_y",          64'(bus.y),     64'd0);
            chk("mul_flags",      64'(bus.flags), 64'b0101);
        end
        run_op("mul_small", 3'd7, 32'd6, 32'd7, 32'd42, 4'b0000);
`else
        run_op("mul_off", 3'd7, 32'd7, 32'd9, 32'd0, 4'b0100);
        chk("mul_off_busy", 64'(bus.busy), 64'd0);
`endif

        run_op("pre_rst", 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000);
        issue(3'd7, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  64'(bus.busy),  64'd0);
        chk("abort_done",  64'(bus.done),  64'd0);
        chk("abort_y",     64'(bus.y),     64'd0);
        chk("abort_flags", 64'(bus.flags), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("post_rst_add", 3'd0, 32'd2, 32'd3, 32'd5, 4'b0000);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            bus.start = ($urandom_range(0, 2) != 0);
            bus.func  = 3'($urandom_range(0, 7));
            bus.a     = rnd_val();
            bus.b     = rnd_val();
        end
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
